// File: rtl/reset_conditioner.sv
// Reset conditioner for the Propeller core: synchronizes and debounces the pushbutton and plug RES line, then stretches the result into one clean active-low reset.
// Latency: resn falls DEBOUNCE_CYCLES+3 edges after a sustained low source is first sampled, and rises DEBOUNCE_CYCLES+3+STRETCH_CYCLES edges after the last source is first sampled high.
// Backpressure: none; the inputs are free-running levels, and glitches shorter than DEBOUNCE_CYCLES synchronized cycles are ignored.
module reset_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter int STRETCH_CYCLES  = 160000
) (
  input  logic       clock_160,
  input  logic       reset,
  input  logic       key_n,
  input  logic       res_pin_n,
  output logic       resn,
  output logic [2:0] cause,
  output logic [7:0] reset_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ST_W = (STRETCH_CYCLES  > 2) ? $clog2(STRETCH_CYCLES)  : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STRETCH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_POR,
    ST_RUN,
    ST_ACTIVE,
    ST_STRETCH
  } state_t;

  logic            r_key_s1, r_key_s2;
  logic            r_plug_s1, r_plug_s2;
  logic            r_key_db, r_plug_db;
  logic [DB_W-1:0] r_key_cnt, r_plug_cnt;
  logic [ST_W-1:0] r_st_cnt;
  state_t          r_state;
  logic            r_resn;
  logic [2:0]      r_cause;
  logic [7:0]      r_reset_count;

  logic            w_any_low;
  logic [2:0]      w_cause_ld;

  // Two-flop synchronizers; idle (released) level is 1.
  always_ff @(posedge clock_160) begin
    if (reset) begin
      r_key_s1  <= 1'b1;
      r_key_s2  <= 1'b1;
      r_plug_s1 <= 1'b1;
      r_plug_s2 <= 1'b1;
    end else begin
      r_key_s1  <= key_n;
      r_key_s2  <= r_key_s1;
      r_plug_s1 <= res_pin_n;
      r_plug_s2 <= r_plug_s1;
    end
  end

  // Pushbutton debounce: level flips only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clock_160) begin
    if (reset) begin
      r_key_db  <= 1'b1;
      r_key_cnt <= '0;
    end else if (r_key_s2 != r_key_db) begin
      if (r_key_cnt == DB_LAST) begin
        r_key_db  <= ~r_key_db;
        r_key_cnt <= '0;
      end else begin
        r_key_cnt <= r_key_cnt + 1'b1;
      end
    end else begin
      r_key_cnt <= '0;
    end
  end

  // Plug RES line debounce, same rule as the pushbutton.
  always_ff @(posedge clock_160) begin
    if (reset) begin
      r_plug_db  <= 1'b1;
      r_plug_cnt <= '0;
    end else if (r_plug_s2 != r_plug_db) begin
      if (r_plug_cnt == DB_LAST) begin
        r_plug_db  <= ~r_plug_db;
        r_plug_cnt <= '0;
      end else begin
        r_plug_cnt <= r_plug_cnt + 1'b1;
      end
    end else begin
      r_plug_cnt <= '0;
    end
  end

  assign w_any_low  = ~r_key_db | ~r_plug_db;
  assign w_cause_ld = {~r_plug_db, ~r_key_db, 1'b0};

  // Reset sequencing FSM; resn is registered alongside the state so it is high only in RUN.
  always_ff @(posedge clock_160) begin
    if (reset) begin
      r_state       <= ST_POR;
      r_st_cnt      <= '0;
      r_resn        <= 1'b0;
      r_cause       <= 3'b001;
      r_reset_count <= 8'd0;
    end else begin
      r_resn <= 1'b0;
      case (r_state)
        ST_POR: begin
          if (w_any_low) begin
            r_state <= ST_ACTIVE;
            r_cause <= w_cause_ld;
          end else if (r_st_cnt == ST_LAST) begin
            r_state  <= ST_RUN;
            r_resn   <= 1'b1;
            r_st_cnt <= '0;
          end else begin
            r_st_cnt <= r_st_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (w_any_low) begin
            r_state <= ST_ACTIVE;
            r_cause <= w_cause_ld;
            if (r_reset_count != 8'hFF) begin
              r_reset_count <= r_reset_count + 8'd1;
            end
          end else begin
            r_resn <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          r_st_cnt <= '0;
          if (!w_any_low) begin
            r_state <= ST_STRETCH;
          end
        end
        ST_STRETCH: begin
          if (w_any_low) begin
            r_state  <= ST_ACTIVE;
            r_cause  <= w_cause_ld;
            r_st_cnt <= '0;
          end else if (r_st_cnt == ST_LAST) begin
            r_state  <= ST_RUN;
            r_resn   <= 1'b1;
            r_st_cnt <= '0;
          end else begin
            r_st_cnt <= r_st_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= ST_POR;
          r_st_cnt <= '0;
        end
      endcase
    end
  end

  assign resn        = r_resn;
  assign cause       = r_cause;
  assign reset_count = r_reset_count;

endmodule

// File: tb/tb_reset_conditioner.sv
// Directed bench for reset_conditioner with DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8.
// Fall latency is 7 edges and release latency is 15 edges from the first edge that samples the new level.
// Inputs change 1 ns after a rising edge, and outputs are sampled at the same point.
module tb_reset_conditioner;

  logic       clk;
  logic       reset;
  logic       key_n;
  logic       res_pin_n;
  logic       resn;
  logic [2:0] cause;
  logic [7:0] reset_count;

  int checks = 0;
  int errors = 0;
  logic flag;

  reset_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .STRETCH_CYCLES (8)
  ) dut (
    .clock_160  (clk),
    .reset      (reset),
    .key_n      (key_n),
    .res_pin_n  (res_pin_n),
    .resn       (resn),
    .cause      (cause),
    .reset_count(reset_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    key_n     = 1'b1;
    res_pin_n = 1'b1;

    // Power-on: reset held for 3 edges.
    tick(3);
    check("reset_resn",  8'(resn),  8'd0);
    check("reset_cause", 8'(cause), 8'h01);
    check("reset_count", reset_count, 8'd0);

    // POR hold: resn rises on the 8th edge with reset low.
    reset = 1'b0;
    tick(7);
    check("por_edge7_resn", 8'(resn), 8'd0);
    tick(1);
    check("por_edge8_resn", 8'(resn), 8'd1);
    check("por_cause", 8'(cause), 8'h01);

    // Key press: 20 cycles low.
    key_n = 1'b0;
    tick(6);
    check("key_edge6_resn", 8'(resn), 8'd1);
    tick(1);
    check("key_edge7_resn", 8'(resn), 8'd0);
    check("key_cause", 8'(cause), 8'h02);
    check("key_count", reset_count, 8'd1);
    tick(13);
    key_n = 1'b1;
    tick(14);
    check("key_rel14_resn", 8'(resn), 8'd0);
    tick(1);
    check("key_rel15_resn", 8'(resn), 8'd1);
    check("key_cause_sticky", 8'(cause), 8'h02);

    // Glitch: 3 cycles low must be ignored.
    flag = 1'b1;
    key_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (resn !== 1'b1) flag = 1'b0;
    end
    key_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (resn !== 1'b1) flag = 1'b0;
    end
    check("glitch_resn_high", 8'(flag), 8'd1);
    check("glitch_cause", 8'(cause), 8'h02);
    check("glitch_count", reset_count, 8'd1);

    // Both sources low on the same edge.
    key_n     = 1'b0;
    res_pin_n = 1'b0;
    tick(7);
    check("both_resn",  8'(resn),  8'd0);
    check("both_cause", 8'(cause), 8'h06);
    check("both_count", reset_count, 8'd2);
    key_n     = 1'b1;
    res_pin_n = 1'b1;
    tick(14);
    check("both_rel14_resn", 8'(resn), 8'd0);
    tick(1);
    check("both_rel15_resn", 8'(resn), 8'd1);

    // Plug re-asserted while stretching after a key press.
    key_n = 1'b0;
    tick(7);
    check("re_key_count", reset_count, 8'd3);
    tick(3);
    key_n = 1'b1;
    flag = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (resn !== 1'b0) flag = 1'b0;
    end
    res_pin_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (resn !== 1'b0) flag = 1'b0;
    end
    check("re_held_low", 8'(flag), 8'd1);
    check("re_cause", 8'(cause), 8'h04);
    check("re_count", reset_count, 8'd3);
    res_pin_n = 1'b1;
    tick(14);
    check("re_rel14_resn", 8'(resn), 8'd0);
    tick(1);
    check("re_rel15_resn", 8'(resn), 8'd1);
    check("re_cause_sticky", 8'(cause), 8'h04);

    // Block reset while ACTIVE.
    key_n = 1'b0;
    tick(7);
    check("mid_active_resn",  8'(resn), 8'd0);
    check("mid_active_count", reset_count, 8'd4);
    reset = 1'b1;
    key_n = 1'b1;
    tick(1);
    check("mid_reset_resn",  8'(resn),  8'd0);
    check("mid_reset_cause", 8'(cause), 8'h01);
    check("mid_reset_count", reset_count, 8'd0);
    reset = 1'b0;
    tick(7);
    check("mid_por7_resn", 8'(resn), 8'd0);
    tick(1);
    check("mid_por8_resn", 8'(resn), 8'd1);

    // Saturation: 260 press/release events.
    for (int e = 0; e < 260; e++) begin
      key_n = 1'b0;
      tick(8);
      key_n = 1'b1;
      tick(16);
      if (e == 253) check("sat_254", reset_count, 8'd254);
    end
    check("sat_255", reset_count, 8'd255);
    check("sat_resn", 8'(resn), 8'd1);
    check("sat_cause", 8'(cause), 8'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
